// File: rtl/hdmi_timing_pkg.sv
// Shared raster constants, frame-length helper and controller state type
// for the HDMI frame-buffer timing generator.
package hdmi_timing_pkg;

    // 1080p60 at two pixels per clock: all horizontal values are in clocks
    localparam int H_ACTIVE_1080P = 960;
    localparam int H_FP_1080P     = 44;
    localparam int H_SYNC_1080P   = 22;
    localparam int H_BP_1080P     = 74;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Total length of one axis: active, front porch, sync, back porch
    function automatic int total_len(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/hdmi_raster_cnt.sv
// Horizontal/vertical raster counters with region decode. The load input
// places the raster at the first vertical-sync line so that a new stream
// always opens with a sync pulse.
module hdmi_raster_cnt
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080P,
    parameter int H_FP     = H_FP_1080P,
    parameter int H_SYNC   = H_SYNC_1080P,
    parameter int H_BP     = H_BP_1080P,
    parameter int V_ACTIVE = V_ACTIVE_1080P,
    parameter int V_FP     = V_FP_1080P,
    parameter int V_SYNC   = V_SYNC_1080P,
    parameter int V_BP     = V_BP_1080P
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_adv,
    output logic o_de_n,
    output logic o_hs_n,
    output logic o_vs_n,
    output logic o_sync_start,
    output logic o_last
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_START = V_W'(V_ACTIVE + V_FP);

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;

    // Next count: load to sync start, or advance with line/frame wrap
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (i_load) begin
            h_cnt_d = '0;
            v_cnt_d = V_START;
        end else if (i_adv) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region decode from the current count
    always_comb begin
        o_de_n       = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        o_hs_n       = !((int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                         (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC));
        o_vs_n       = !((int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                         (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC));
        o_sync_start = (h_cnt_q == '0) && (v_cnt_q == V_START);
        o_last       = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

endmodule

// File: rtl/hdmi_fb_timing_gen.sv
// Frame-buffer reader and 2-pixel-per-clock raster generator. Pops one word
// per active clock from an FWFT FIFO; an empty FIFO during active video
// yields a zero word so the raster geometry never changes.
module hdmi_fb_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080P,
    parameter int H_FP     = H_FP_1080P,
    parameter int H_SYNC   = H_SYNC_1080P,
    parameter int H_BP     = H_BP_1080P,
    parameter int V_ACTIVE = V_ACTIVE_1080P,
    parameter int V_FP     = V_FP_1080P,
    parameter int V_SYNC   = V_SYNC_1080P,
    parameter int V_BP     = V_BP_1080P
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_rd_data,
    output logic        o_fifo_rd_en,
    output logic        o_frame_start,
    output logic        o_de,
    output logic        o_valid,
    output logic        o_hs,
    output logic        o_vs,
    output logic [31:0] o_data,
    output logic        o_underflow,
    output logic [15:0] o_underflow_cnt
);

    state_e      state_q, state_d;
    logic        stop_q, stop_d;
    logic        run;
    logic        de_n, hs_n, vs_n, sync_start, last;
    logic        rd_en, ufl_hit;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [31:0] data_q, data_d;
    logic        ufl_q, ufl_d;
    logic [15:0] ufl_cnt_q, ufl_cnt_d;

    assign run = (state_q == RUN);

    hdmi_raster_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_raster (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       ((state_q == IDLE) && i_en),
        .i_adv        (run),
        .o_de_n       (de_n),
        .o_hs_n       (hs_n),
        .o_vs_n       (vs_n),
        .o_sync_start (sync_start),
        .o_last       (last)
    );

    // State register and pending-stop flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    // Next state: a stop request only takes effect on the final back-porch clock
    always_comb begin
        stop_d = stop_q;
        if (i_en) begin
            stop_d = 1'b0;
        end else if (run) begin
            stop_d = 1'b1;
        end
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_en) state_d = RUN;
            RUN:     if (last && stop_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: FIFO pop, underflow detect and next registered outputs
    always_comb begin
        rd_en     = run && de_n && !i_fifo_empty;
        ufl_hit   = run && de_n && i_fifo_empty;
        de_d      = run && de_n;
        hs_d      = !run || hs_n;
        vs_d      = !run || vs_n;
        fs_d      = run && sync_start;
        data_d    = rd_en ? i_fifo_rd_data : 32'h0;
        ufl_d     = ufl_q || ufl_hit;
        ufl_cnt_d = (ufl_hit && (ufl_cnt_q != 16'hFFFF)) ? ufl_cnt_q + 16'd1 : ufl_cnt_q;
    end

    // Output registers, one clock behind the counter state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            fs_q      <= 1'b0;
            data_q    <= 32'h0;
            ufl_q     <= 1'b0;
            ufl_cnt_q <= 16'h0;
        end else begin
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
            data_q    <= data_d;
            ufl_q     <= ufl_d;
            ufl_cnt_q <= ufl_cnt_d;
        end
    end

    assign o_fifo_rd_en    = rd_en;
    assign o_frame_start   = fs_q;
    assign o_de            = de_q;
    assign o_valid         = de_q;
    assign o_hs            = hs_q;
    assign o_vs            = vs_q;
    assign o_data          = data_q;
    assign o_underflow     = ufl_q;
    assign o_underflow_cnt = ufl_cnt_q;

endmodule

// File: tb/tb_hdmi_fb_timing_gen.sv
// Bench for the HDMI frame-buffer timing generator: a small-raster instance
// checked cycle by cycle against a position-based reference, plus a
// saturation instance and a default-1080p instance running alongside.
module tb_hdmi_fb_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int START = (VA + VF) * HT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Main small-raster instance
    logic        rst, en, empty;
    logic [31:0] fdata;
    logic        rd, fs, de, valid, hs, vs, ufl;
    logic [31:0] data;
    logic [15:0] ucnt;

    hdmi_fb_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_en (en), .i_fifo_empty (empty),
        .i_fifo_rd_data (fdata), .o_fifo_rd_en (rd), .o_frame_start (fs),
        .o_de (de), .o_valid (valid), .o_hs (hs), .o_vs (vs), .o_data (data),
        .o_underflow (ufl), .o_underflow_cnt (ucnt)
    );

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [31:0] data;
        logic        ufl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: running flag and linear position within the frame
    bit md_run = 0;
    int md_p   = 0;
    bit md_ufl = 0;
    int md_cnt = 0;

    // One clock: predict from the reference, push, clock, pop and compare
    task automatic step();
        exp_t e;
        int   h, v;
        bit   e_de, e_rd;
        #1;
        h    = md_p % HT;
        v    = md_p / HT;
        e_de = md_run && (h < HA) && (v < VA);
        e_rd = e_de && !empty;
        check_val("rd_en", {31'b0, rd}, {31'b0, e_rd});
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.data = 32'h0;
        if (rst) begin
            md_run = 0; md_p = 0; md_ufl = 0; md_cnt = 0;
        end else if (!md_run) begin
            if (en) begin
                md_run = 1;
                md_p   = START;
            end
        end else begin
            e.de   = e_de;
            e.hs   = !((h >= HA + HF) && (h < HA + HF + HS));
            e.vs   = !((v >= VA + VF) && (v < VA + VF + VS));
            e.fs   = (md_p == START);
            e.data = e_rd ? fdata : 32'h0;
            if (e_de && empty) begin
                md_ufl = 1;
                if (md_cnt < 65535) md_cnt++;
            end
            if (md_p == FR - 1 && !en) begin
                md_run = 0;
                md_p   = 0;
            end else begin
                md_p = (md_p + 1) % FR;
            end
        end
        e.ufl = md_ufl;
        e.cnt = 16'(md_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (e_rd) fdata = fdata + 32'd1;
        e = exp_q.pop_front();
        check_val("de",       {31'b0, de},    {31'b0, e.de});
        check_val("valid",    {31'b0, valid}, {31'b0, e.de});
        check_val("hs",       {31'b0, hs},    {31'b0, e.hs});
        check_val("vs",       {31'b0, vs},    {31'b0, e.vs});
        check_val("fs",       {31'b0, fs},    {31'b0, e.fs});
        check_val("data",     data,           e.data);
        check_val("ufl",      {31'b0, ufl},   {31'b0, e.ufl});
        check_val("ufl_cnt",  {16'b0, ucnt},  {16'b0, e.cnt});
    endtask

    // Saturation instance: FIFO permanently empty on a wide, tall raster
    logic        s_rst, s_en, s_empty;
    logic [31:0] s_fdata;
    logic        s_rd, s_fs, s_de, s_valid, s_hs, s_vs, s_ufl;
    logic [31:0] s_data;
    logic [15:0] s_cnt;
    bit          sat_done = 0;

    hdmi_fb_timing_gen #(
        .H_ACTIVE (2000), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (33), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_sat (
        .i_clk (clk), .i_rst (s_rst), .i_en (s_en), .i_fifo_empty (s_empty),
        .i_fifo_rd_data (s_fdata), .o_fifo_rd_en (s_rd), .o_frame_start (s_fs),
        .o_de (s_de), .o_valid (s_valid), .o_hs (s_hs), .o_vs (s_vs), .o_data (s_data),
        .o_underflow (s_ufl), .o_underflow_cnt (s_cnt)
    );

    initial begin
        int n;
        s_rst = 1'b1; s_en = 1'b1; s_empty = 1'b1; s_fdata = 32'hDEAD_BEEF;
        @(posedge clk); @(posedge clk); #1;
        s_rst = 1'b0;
        n = 0;
        for (int c = 0; c < 90000 && n < 65540; c++) begin
            @(negedge clk);
            if (s_de) begin
                n++;
                if (n == 1) begin
                    check_val("sat_first_data",  s_data, 32'h0);
                    check_val("sat_first_valid", {31'b0, s_valid}, 32'd1);
                    check_val("sat_first_cnt",   {16'b0, s_cnt}, 32'd1);
                end
                if (n == 65534) check_val("sat_pre_cnt", {16'b0, s_cnt}, 32'd65534);
            end
        end
        if (n < 65540) begin
            check_val("sat_timeout", n, 65540);
        end else begin
            check_val("sat_cnt",   {16'b0, s_cnt}, 32'h0000_FFFF);
            check_val("sat_flag",  {31'b0, s_ufl}, 32'd1);
            check_val("sat_data",  s_data, 32'h0);
            check_val("sat_valid", {31'b0, s_valid}, 32'd1);
        end
        sat_done = 1;
    end

    // Default-parameter instance: sync-to-active distance and one full line
    logic        d_rst, d_en, d_empty;
    logic [31:0] d_fdata;
    logic        d_rd, d_fs, d_de, d_valid, d_hs, d_vs, d_ufl;
    logic [31:0] d_data;
    logic [15:0] d_cnt;
    bit          def_done = 0;

    hdmi_fb_timing_gen dut_def (
        .i_clk (clk), .i_rst (d_rst), .i_en (d_en), .i_fifo_empty (d_empty),
        .i_fifo_rd_data (d_fdata), .o_fifo_rd_en (d_rd), .o_frame_start (d_fs),
        .o_de (d_de), .o_valid (d_valid), .o_hs (d_hs), .o_vs (d_vs), .o_data (d_data),
        .o_underflow (d_ufl), .o_underflow_cnt (d_cnt)
    );

    initial begin
        int  c, dn, rn, hn;
        bit  seen;
        d_rst = 1'b1; d_en = 1'b1; d_empty = 1'b0; d_fdata = 32'h1234_5678;
        @(posedge clk); @(posedge clk); #1;
        d_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = d_fs;
        end
        check_val("def_fs_seen", {31'b0, seen}, 32'd1);
        check_val("def_fs_vs", {31'b0, d_vs}, 32'd0);
        c = 0;
        while (!d_de && c < 50000) begin
            @(negedge clk);
            c++;
        end
        check_val("def_sync_to_active", c, 45100);
        check_val("def_first_data", d_data, 32'h1234_5678);
        dn = 0; rn = 0; hn = 0;
        for (int k = 0; k < 1100; k++) begin
            dn += int'(d_de);
            rn += int'(d_rd);
            hn += int'(!d_hs);
            @(negedge clk);
        end
        check_val("def_line_de",  dn, 960);
        check_val("def_line_pops", rn, 960);
        check_val("def_line_hs",  hn, 22);
        check_val("def_ufl_cnt",  {16'b0, d_cnt}, 32'd0);
        def_done = 1;
    end

    // Main sequence on the small raster
    initial begin
        rst = 1'b1; en = 1'b0; empty = 1'b0; fdata = 32'h0;
        @(posedge clk); #1;
        // Reset values
        step(); step();
        rst = 1'b0;
        step();
        // Start with a full FIFO for two frames
        en = 1'b1;
        repeat (2 * FR + 4) step();
        check_val("full_ufl_cnt", {16'b0, ucnt}, 32'd0);
        // Two empty clocks in the middle of line 1 of one frame
        for (int i = 0; i < 2 * FR; i++) begin
            empty = md_run && (md_cnt < 2) && (md_p / HT == 1) &&
                    ((md_p % HT == 1) || (md_p % HT == 2));
            step();
        end
        empty = 1'b0;
        check_val("ufl_flag", {31'b0, ufl}, 32'd1);
        check_val("ufl_cnt2", {16'b0, ucnt}, 32'd2);
        // Stop request during line 0: frame completes, then idle
        for (int i = 0; i < 2 * FR && !(md_run && md_p == 1); i++) step();
        en = 1'b0;
        for (int i = 0; i < 2 * FR && md_run; i++) step();
        repeat (5) step();
        check_val("idle_hs", {31'b0, hs}, 32'd1);
        check_val("idle_vs", {31'b0, vs}, 32'd1);
        check_val("idle_de", {31'b0, de}, 32'd0);
        // Restart, drop and re-assert before frame end: no stop
        en = 1'b1;
        for (int i = 0; i < 2 * FR && !(md_run && md_p == 2); i++) step();
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (2 * FR) step();
        // Reset in the middle of an active line, then restart
        for (int i = 0; i < 2 * FR && !(md_run && md_p == HT + 2); i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (FR + 4) step();
        wait (sat_done && def_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
